// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router: flit type encodings, the packet
// length field width and the per-port framing state.
package noc_pkg;

   localparam logic [2:0] FLIT_HEADER = 3'b001;
   localparam logic [2:0] FLIT_BODY   = 3'b010;
   localparam logic [2:0] FLIT_TAIL   = 3'b100;

   localparam int LEN_W = 12;

   typedef enum logic {
      IDLE,
      ACTIVE
   } port_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty flags. A write is refused while full even
// if a read happens in the same cycle, because there is no fall-through path.
// Reads that arrive while the FIFO is empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr_q, wrPtr_d;
   logic [AW-1:0]    rdPtr_q, rdPtr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             doWrite;
   logic             doRead;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign doWrite = wr_en && !full;
   assign doRead  = rd_en && !empty;
   assign rd_data = mem[rdPtr_q];

   // Next pointer and occupancy values; a simultaneous write and read leave the count unchanged.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doWrite) begin
         wrPtr_d = wrPtr_q + AW'(1);
      end
      if (doRead) begin
         rdPtr_d = rdPtr_q + AW'(1);
      end
      if (doWrite && !doRead) begin
         count_d = count_q + CW'(1);
      end else if (doRead && !doWrite) begin
         count_d = count_q - CW'(1);
      end
   end

   // Pointer and count registers, cleared by reset so stored entries are forgotten.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage array; contents need no reset because the count guards every read.
   always_ff @(posedge clk) begin
      if (doWrite) begin
         mem[wrPtr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/input_port_buffer.sv
// Per-port input stage of the mesh router. Buffers incoming flits, tracks
// packet framing and presents head flit type, packet length and a request
// to the output-port arbiter. Stray body/tail flits seen outside a packet
// are dropped automatically and flagged on err.
module input_port_buffer
   import noc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [2:0]        in_flit_id,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              rd_en,
   output logic              req,
   output logic [2:0]        flit_id,
   output logic [LEN_W-1:0]  length,
   output logic [DATA_W-1:0] out_data,
   output logic              pkt_done,
   output logic              err
);

   localparam int FW = DATA_W + 3;

   port_state_t      state_q;
   logic [LEN_W-1:0] length_q;
   logic [LEN_W-1:0] remaining_q;
   logic             pktDone_q;
   logic             err_q;

   logic [FW-1:0]     headWord;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [2:0]        headId;
   logic [DATA_W-1:0] headData;
   logic [LEN_W-1:0]  headLen;
   logic              headIsHeader;
   logic              discard;
   logic              pop;

   sync_fifo #(
      .WIDTH(FW),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (in_valid),
      .wr_data({in_flit_id, in_data}),
      .rd_en  (pop),
      .rd_data(headWord),
      .full   (fifoFull),
      .empty  (fifoEmpty)
   );

   // Head decode, masked to zero while the FIFO is empty.
   always_comb begin
      headId   = 3'b000;
      headData = '0;
      if (!fifoEmpty) begin
         headId   = headWord[DATA_W +: 3];
         headData = headWord[DATA_W-1:0];
      end
   end

   assign headLen      = headData[LEN_W-1:0];
   assign headIsHeader = (headId == FLIT_HEADER);
   assign discard      = (state_q == IDLE) && !fifoEmpty && !headIsHeader;
   assign pop          = !fifoEmpty && (rd_en || discard);

   assign in_ready = !fifoFull;
   assign flit_id  = headId;
   assign out_data = headData;
   assign length   = headIsHeader ? headLen : length_q;
   assign req      = !fifoEmpty && ((state_q == ACTIVE) || headIsHeader);
   assign pkt_done = pktDone_q;
   assign err      = err_q;

   // Framing FSM: follows each popped flit, keeps the packet length and raises done/error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         length_q    <= '0;
         remaining_q <= '0;
         pktDone_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         pktDone_q <= 1'b0;
         err_q     <= 1'b0;
         if (pop) begin
            if (headIsHeader) begin
               length_q <= headLen;
               if (state_q == ACTIVE) begin
                  err_q <= 1'b1;
               end
               if (headLen >= LEN_W'(2)) begin
                  state_q     <= ACTIVE;
                  remaining_q <= headLen - LEN_W'(1);
               end else begin
                  state_q <= IDLE;
               end
            end else if (state_q == IDLE) begin
               err_q <= 1'b1;
            end else if (headId == FLIT_TAIL) begin
               pktDone_q <= 1'b1;
               state_q   <= IDLE;
               if (remaining_q != LEN_W'(1)) begin
                  err_q <= 1'b1;
               end
            end else begin
               if (remaining_q == LEN_W'(1)) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  remaining_q <= remaining_q - LEN_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_input_port_buffer.sv
// Self-checking bench for input_port_buffer: a table of per-cycle vectors
// with hand-computed expectations, plus hand-written full and gap sequences.
module tb_input_port_buffer;

   localparam logic [2:0] HDR = 3'b001;
   localparam logic [2:0] BDY = 3'b010;
   localparam logic [2:0] TL  = 3'b100;
   localparam logic [31:0] H1 = 32'h0000_0001;
   localparam logic [31:0] H3 = 32'h0000_0003;
   localparam logic [31:0] H4 = 32'h0000_0004;
   localparam logic [31:0] BD = 32'hB0DE_0001;
   localparam logic [31:0] TD = 32'h7A11_0002;

   typedef struct {
      logic        rst;
      logic        valid;
      logic [2:0]  id;
      logic [31:0] data;
      logic        rd;
      logic        expReq;
      logic [2:0]  expId;
      logic [11:0] expLen;
      logic [31:0] expData;
      logic        expReady;
      logic        expDone;
      logic        expErr;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [2:0]  in_flit_id;
   logic [31:0] in_data;
   logic        in_ready;
   logic        rd_en;
   logic        req;
   logic [2:0]  flit_id;
   logic [11:0] length;
   logic [31:0] out_data;
   logic        pkt_done;
   logic        err;

   int assertions = 0;
   int failures   = 0;
   vec_t vecs[$];

   input_port_buffer #(.DATA_W(32), .DEPTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_flit_id(in_flit_id),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .rd_en     (rd_en),
      .req       (req),
      .flit_id   (flit_id),
      .length    (length),
      .out_data  (out_data),
      .pkt_done  (pkt_done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic v, input logic [2:0] id,
                               input logic [31:0] d, input logic rd, input logic eReq,
                               input logic [2:0] eId, input logic [11:0] eLen,
                               input logic [31:0] eData, input logic eRdy,
                               input logic eDone, input logic eErr);
      vec_t t;
      t.rst = r; t.valid = v; t.id = id; t.data = d; t.rd = rd;
      t.expReq = eReq; t.expId = eId; t.expLen = eLen; t.expData = eData;
      t.expReady = eRdy; t.expDone = eDone; t.expErr = eErr;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive inputs just after a rising edge, then move to the falling edge for sampling.
   task automatic drive(input logic r, input logic v, input logic [2:0] id,
                        input logic [31:0] d, input logic rd);
      rst        = r;
      in_valid   = v;
      in_flit_id = id;
      in_data    = d;
      rd_en      = rd;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t t);
      drive(t.rst, t.valid, t.id, t.data, t.rd);
   endtask

   task automatic checkOutput(input vec_t t, input int row);
      check($sformatf("row%0d_req", row),      32'(req),      32'(t.expReq));
      check($sformatf("row%0d_flit_id", row),  32'(flit_id),  32'(t.expId));
      check($sformatf("row%0d_length", row),   32'(length),   32'(t.expLen));
      check($sformatf("row%0d_out_data", row), out_data,      t.expData);
      check($sformatf("row%0d_in_ready", row), 32'(in_ready), 32'(t.expReady));
      check($sformatf("row%0d_pkt_done", row), 32'(pkt_done), 32'(t.expDone));
      check($sformatf("row%0d_err", row),      32'(err),      32'(t.expErr));
   endtask

   task automatic doReset();
      drive(1'b1, 1'b0, 3'b000, 32'h0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 3'b000, 32'h0, 1'b0);
      tick();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_flit_id = 3'b000; in_data = '0; rd_en = 1'b0;

      // rst valid id data rd | req id len data ready done err
      // good 3-flit packet with rd_en held high; first row checks reset state
      vecs.push_back(mk(0,1,HDR,H3,1, 0,3'b000,12'd0,32'h0,1,0,0));
      vecs.push_back(mk(0,1,BDY,BD,1, 1,HDR,12'd3,H3,1,0,0));
      vecs.push_back(mk(0,1,TL ,TD,1, 1,BDY,12'd3,BD,1,0,0));
      vecs.push_back(mk(0,0,3'b000,0,1, 1,TL,12'd3,TD,1,0,0));
      vecs.push_back(mk(0,0,3'b000,0,0, 0,3'b000,12'd3,32'h0,1,1,0));
      // header says 4 but only 3 flits arrive
      vecs.push_back(mk(0,1,HDR,H4,0, 0,3'b000,12'd3,32'h0,1,0,0));
      vecs.push_back(mk(0,1,BDY,BD,1, 1,HDR,12'd4,H4,1,0,0));
      vecs.push_back(mk(0,1,TL ,TD,1, 1,BDY,12'd4,BD,1,0,0));
      vecs.push_back(mk(0,0,3'b000,0,1, 1,TL,12'd4,TD,1,0,0));
      vecs.push_back(mk(0,0,3'b000,0,0, 0,3'b000,12'd4,32'h0,1,1,1));
      // reset, then a stray body flit is discarded without rd_en
      vecs.push_back(mk(1,0,3'b000,0,0, 0,3'b000,12'd4,32'h0,1,0,0));
      vecs.push_back(mk(0,1,BDY,BD,0, 0,3'b000,12'd0,32'h0,1,0,0));
      vecs.push_back(mk(0,0,3'b000,0,0, 0,BDY,12'd0,BD,1,0,0));
      vecs.push_back(mk(0,0,3'b000,0,0, 0,3'b000,12'd0,32'h0,1,0,1));
      vecs.push_back(mk(0,0,3'b000,0,0, 0,3'b000,12'd0,32'h0,1,0,0));
      // four flits stored mid-packet, then reset
      vecs.push_back(mk(0,1,HDR,H4,0, 0,3'b000,12'd0,32'h0,1,0,0));
      vecs.push_back(mk(0,1,BDY,BD,0, 1,HDR,12'd4,H4,1,0,0));
      vecs.push_back(mk(0,1,BDY,BD,0, 1,HDR,12'd4,H4,1,0,0));
      vecs.push_back(mk(0,1,TL ,TD,0, 1,HDR,12'd4,H4,1,0,0));
      vecs.push_back(mk(0,1,BDY,BD,1, 1,HDR,12'd4,H4,1,0,0));
      vecs.push_back(mk(1,0,3'b000,0,0, 1,BDY,12'd4,BD,1,0,0));
      vecs.push_back(mk(0,0,3'b000,0,0, 0,3'b000,12'd0,32'h0,1,0,0));
      // rd_en on an empty FIFO, then a single-flit (len=1) header
      vecs.push_back(mk(0,0,3'b000,0,1, 0,3'b000,12'd0,32'h0,1,0,0));
      vecs.push_back(mk(0,1,HDR,H1,0, 0,3'b000,12'd0,32'h0,1,0,0));
      vecs.push_back(mk(0,0,3'b000,0,1, 1,HDR,12'd1,H1,1,0,0));
      vecs.push_back(mk(0,0,3'b000,0,0, 0,3'b000,12'd1,32'h0,1,0,0));
      // header arriving mid-packet restarts it with an error, then a short tail
      vecs.push_back(mk(0,1,HDR,H3,0, 0,3'b000,12'd1,32'h0,1,0,0));
      vecs.push_back(mk(0,1,HDR,H4,1, 1,HDR,12'd3,H3,1,0,0));
      vecs.push_back(mk(0,0,3'b000,0,1, 1,HDR,12'd4,H4,1,0,0));
      vecs.push_back(mk(0,0,3'b000,0,0, 0,3'b000,12'd4,32'h0,1,0,1));
      vecs.push_back(mk(0,1,TL ,TD,0, 0,3'b000,12'd4,32'h0,1,0,0));
      vecs.push_back(mk(0,0,3'b000,0,1, 1,TL,12'd4,TD,1,0,0));
      vecs.push_back(mk(0,0,3'b000,0,0, 0,3'b000,12'd4,32'h0,1,1,1));
      vecs.push_back(mk(0,0,3'b000,0,0, 0,3'b000,12'd4,32'h0,1,0,0));

      doReset();
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], i);
         tick();
      end

      // fill all eight entries, refuse a ninth, recover after one pop
      doReset();
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, HDR, 32'(16 + i), 0);
         check($sformatf("fill%0d_in_ready", i), 32'(in_ready), 32'd1);
         tick();
      end
      drive(0, 1, HDR, 32'h99, 0);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_head_data", out_data, 32'd16);
      tick();
      drive(0, 0, 3'b000, 32'h0, 1);
      check("full_before_pop", 32'(in_ready), 32'd0);
      tick();
      drive(0, 0, 3'b000, 32'h0, 0);
      check("ready_after_pop", 32'(in_ready), 32'd1);
      check("head_after_pop", out_data, 32'd17);
      tick();
      for (int i = 1; i < 8; i++) begin
         drive(0, 0, 3'b000, 32'h0, 1);
         check($sformatf("drain%0d_data", i), out_data, 32'(16 + i));
         tick();
      end
      drive(0, 0, 3'b000, 32'h0, 0);
      check("ninth_not_stored", 32'(flit_id), 32'd0);
      check("drained_in_ready", 32'(in_ready), 32'd1);
      tick();

      // FIFO runs dry mid-packet: req drops, then returns with the tail
      doReset();
      drive(0, 1, HDR, H3, 0);
      tick();
      drive(0, 1, BDY, BD, 1);
      check("gap_hdr_req", 32'(req), 32'd1);
      check("gap_hdr_id", 32'(flit_id), 32'(HDR));
      tick();
      drive(0, 0, 3'b000, 32'h0, 1);
      check("gap_body_id", 32'(flit_id), 32'(BDY));
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 3'b000, 32'h0, 1);
         check($sformatf("gap%0d_req", i), 32'(req), 32'd0);
         tick();
      end
      drive(0, 1, TL, TD, 0);
      check("gap_pre_tail_req", 32'(req), 32'd0);
      tick();
      drive(0, 0, 3'b000, 32'h0, 1);
      check("gap_tail_req", 32'(req), 32'd1);
      check("gap_tail_id", 32'(flit_id), 32'(TL));
      check("gap_tail_len", 32'(length), 32'd3);
      tick();
      drive(0, 0, 3'b000, 32'h0, 0);
      check("gap_pkt_done", 32'(pkt_done), 32'd1);
      check("gap_err", 32'(err), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/input_port_buffer.md
# input_port_buffer

Per-port input stage of the 5-port mesh router, placed directly upstream of the output-port arbiter. It buffers incoming flits in a small FIFO and tracks packet framing. It presents the head flit's `flit_id`, the packet `length` and a `req` line in exactly the form the arbiter and its per-port timers consume. One instance exists per port (L, N, E, W, S); the arbiter/crossbar grant pops flits through `rd_en`.

## Interface
- `DATA_W`, 32: flit payload width; must be ≥ 12.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream flit present.
- `in_flit_id`  in  3  upstream flit type (one-hot: 001 header, 010 body, 100 tail).
- `in_data`  in  DATA_W  upstream payload; for a header, bits [11:0] carry the packet length in flits, header and tail included.
- `in_ready`  out  1  buffer can accept; equals !full.
- `rd_en`  in  1  pop head flit (granted and forwarded this cycle).
- `req`  out  1  request to arbiter.
- `flit_id`  out  3  head flit type; 000 when empty.
- `length`  out  12  current packet length.
- `out_data`  out  DATA_W  head payload; 0 when empty.
- `pkt_done`  out  1  one-cycle pulse when a tail flit is popped.
- `err`  out  1  one-cycle pulse on a framing violation.

## Operation
- FIFO stores {flit_id, data}. Write when `in_valid && in_ready`; pop when `rd_en && !empty`. `rd_en` while empty is ignored.
- Full: `in_ready`=0; no write. This holds even when a pop occurs in the same cycle, because there is no fall-through.
- Simultaneous write and pop when neither full nor empty: both happen, and the count is unchanged.
- `flit_id` and `out_data` are driven combinationally from the FIFO head.
- `length` = head `data[11:0]` when the head is a header; otherwise it is the registered `length_q`. `length_q` loads when a header is popped.
- Framing FSM, states IDLE and ACTIVE, with a 12-bit `remaining` register:
  - IDLE, header popped, length ≥ 2: go to ACTIVE with `remaining` = length−1.
  - IDLE, header popped, length ≤ 1: treat as a single-flit packet and stay in IDLE. `pkt_done` is not pulsed.
  - IDLE, body or tail at head: flit is silently discarded at 1 per cycle without `rd_en`; `err` pulses for each discarded flit. `req` is not asserted.
  - ACTIVE, body popped: `remaining`−1.
  - ACTIVE, tail popped: `pkt_done` pulses and the FSM returns to IDLE. If `remaining` ≠ 1, `err` also pulses.
  - ACTIVE, header popped: `err` pulses and a new packet starts from that header (`remaining` reloads).
  - ACTIVE, body popped with `remaining` = 1: `err` pulses and the FSM returns to IDLE.
- `req` = !empty && (state==ACTIVE || head is header).
- `req` drops while ACTIVE if the FIFO runs empty. It reasserts when the next flit arrives, and the arbiter re-grants it.

## Timing
- Reset:
  - pointers and count are 0; state is IDLE.
  - `length_q` and `remaining` are 0.
  - `in_ready`=1.
  - `req`, `flit_id`, `out_data`, `length`, `pkt_done` and `err` are all 0.
- Write latency: a flit accepted at edge n is visible on `flit_id`/`req` after edge n and usable by the arbiter in cycle n+1.
- The pop takes effect at the edge where `rd_en` is sampled high. The next head appears in the following cycle.
- `pkt_done` and `err` are registered pulses, asserted in the cycle after the causing pop.
- Reset mid-packet discards all stored flits and returns to IDLE on the next edge.
- Throughput: 1 flit/cycle in and out sustained.

## Structure
- Shared package `noc_pkg` holds:
  - `FLIT_HEADER`=3'b001, `FLIT_BODY`=3'b010, `FLIT_TAIL`=3'b100;
  - `LEN_W`=12;
  - the state enum `port_state_t` {IDLE, ACTIVE}.
- Sub-module `sync_fifo`, parameterised by width and depth, with full/empty flags and no fall-through. The framing FSM and output logic stay in `input_port_buffer`.

## Test plan
- Reset, then push header(len=3), body, tail; `rd_en` held high → `req`=1 and `flit_id`=001, `length`=3 in the first cycle. Then 010, then 100. `pkt_done` pulses once, `err` stays 0, and `req`=0 afterwards.
- Push 8 flits with `rd_en`=0 (DEPTH=8) → `in_ready`=0 after the 8th; a 9th `in_valid` is not stored. One pop brings `in_ready` back to 1 the next cycle.
- Body flit as the first flit after reset → discarded with no `rd_en`; `err` pulses once and `req` never asserts.
- Header(len=4), body, tail → the tail pop pulses both `pkt_done` and `err`, and the FSM returns to IDLE.
- Header(len=3), body, then FIFO empty for 5 cycles → `req`=0 during the gap. After the tail is pushed, `req`=1 with `flit_id`=100 and `length`=3 held.
- Assert `rst` mid-packet with 4 flits stored → next cycle: empty, `req`=0, `in_ready`=1, `length`=0.
